fb_arbiter: RTL
===============

Name: fb_arbiter

Overview:
- Owns the single-port frame RAM behind the LED matrix.
- Shares it between two requesters: the display scan path, which issues pixel reads at the row/col the sequencer is currently writing, and a host write port.
- Display reads have absolute priority and a fixed latency. Host writes drain through a 1-entry buffer in free cycles.
- A built-in clear engine zero-fills the RAM.

Parameters:
- ROW_W, 3, width of sequencer row index (8 scan rows).
- COL_W, 8, width of sequencer col index (32*NUM_PANELS columns).
- DATA_W, 6, pixel word width {r1,g1,b1,r2,g2,b2}.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rd_req  in  1  display read strobe, 1-cycle pulse
- rd_row  in  ROW_W  read row
- rd_col  in  COL_W  read col
- rd_valid  out  1  read data valid, 1-cycle pulse
- rd_data  out  DATA_W  read pixel word
- wr_valid  in  1  host write request
- wr_ready  out  1  host write accepted when wr_valid&wr_ready
- wr_addr  in  ROW_W+COL_W  host write address {row,col}
- wr_data  in  DATA_W  host write data
- clr_req  in  1  start zero-fill, 1-cycle pulse
- clr_busy  out  1  clear in progress
- frame_end  in  1  pulse from sequencer at last col of row 7
- swap_req  in  1  request bank swap; used only with DOUBLE_BUF_EN
- swap_done  out  1  pulse when swap executes
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  AW = ROW_W+COL_W, +1 with DOUBLE_BUF_EN
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_en&!ram_we

Behaviour:
- Reset values:
  - rd_valid=0, rd_data=0, wr_ready=1, clr_busy=0, swap_done=0.
  - ram_en/ram_we=0; write buffer empty; FSM=IDLE.
- RAM control (ram_en/ram_we/ram_addr/ram_wdata) is combinational from the current cycle's arbitration decision. Priority per cycle:
  - 1) rd_req, 2) CLEAR access, 3) buffered host write.
- Read:
  - rd_req in cycle N → RAM read at {rd_row,rd_col} in N.
  - rd_data registered at N+2 with rd_valid=1. Fixed latency 2 in all conditions.
  - Contract: rd_req spacing ≥2 cycles; violation is an assertion error.
- Write buffer (1 entry):
  - wr_ready = !full.
  - Handshake loads the buffer; the entry drains in the first cycle with no rd_req and FSM≠CLEAR.
  - Drain and a new accept may occur in the same cycle: wr_ready stays 1, so full throughput is 1 write per free cycle.
- FSM IDLE/CLEAR:
  - clr_req in IDLE → CLEAR; clr_ctr=0; clr_busy=1 next cycle.
  - In CLEAR, each cycle without rd_req writes 0 at clr_ctr, then clr_ctr++.
  - After writing address 2^(ROW_W+COL_W)-1 → IDLE; clr_busy=0.
  - wr_ready=0 while CLEAR and the buffer is full (the buffer holds; it drains after CLEAR).
  - clr_req during CLEAR is ignored.
- Simultaneous rd_req and pending write: the write is stalled, never dropped.
- Reset mid-operation aborts CLEAR and discards the buffer; RAM contents are undefined.
- Widths: clr_ctr is ROW_W+COL_W bits; it terminates on reaching all-ones and does not wrap.

Optional Feature:
- Macro: DOUBLE_BUF_EN
- Enabled:
  - ram_addr MSB is the bank bit. Reads use disp_bank; host writes and clear use ~disp_bank.
  - swap_req sets a sticky swap_pend. At the next frame_end with swap_pend=1 and the write buffer empty, disp_bank toggles, swap_pend clears, and swap_done pulses the following cycle.
  - If the buffer is not empty, the swap defers to a later frame_end.
  - disp_bank resets to 0.
- Disabled:
  - Single bank; AW = ROW_W+COL_W.
  - swap_req and frame_end are ignored; swap_done is tied 0.

Decomposition:
- Package fb_pkg: ROW_W/COL_W/DATA_W defaults, pixel struct {r1,g1,b1,r2,g2,b2}, FSM enum {IDLE, CLEAR}, grant enum {G_NONE, G_RD, G_CLR, G_WR}.
- One natural sub-module: fb_wbuf, the 1-entry write buffer with valid/ready.

Test Plan:
- Reset → rd_valid=0, wr_ready=1, clr_busy=0, ram_en=0; after release, idle cycles produce no RAM access.
- Host writes 0x2A at {3,17}, then rd_req at row 3, col 17 → rd_valid exactly 2 cycles later with rd_data=0x2A.
- wr_valid held, same cycle as rd_req, buffer full → ram_we=0 that cycle; write lands next cycle; wr_ready=0 only while full and stalled; no data lost.
- clr_req with rd_req every 4 cycles → clr_busy high until 2048 zero writes complete; every read still returns at latency 2; subsequent reads return 0.
- Reset asserted at clr_ctr=100 → clr_busy=0 immediately; FSM=IDLE; buffer empty.
- DOUBLE_BUF_EN: write 0x15 to back bank, swap_req, then frame_end → swap_done next cycle; reads return 0x15; without a swap_req, frame_end causes no bank change.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and defaults for the LED frame-buffer arbiter.
// Holds geometry defaults, the pixel word layout, the FSM and grant enums.
// Build option: define DOUBLE_BUF_EN to add a bank bit above the {row,col} address.
package fb_pkg;

    localparam int FB_ROW_W  = 3;   // 8 scan rows
    localparam int FB_COL_W  = 8;   // 32*NUM_PANELS columns
    localparam int FB_DATA_W = 6;   // {r1,g1,b1,r2,g2,b2}

`ifdef DOUBLE_BUF_EN
    localparam int FB_BANK_W = 1;
`else
    localparam int FB_BANK_W = 0;
`endif

    // Upper-half and lower-half colour bits of one scan column.
    typedef struct packed {
        logic r1;
        logic g1;
        logic b1;
        logic r2;
        logic g2;
        logic b2;
    } pixel_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } fsm_e;

    // Owner of the RAM port in the current cycle.
    typedef enum logic [1:0] {
        G_NONE,
        G_RD,
        G_CLR,
        G_WR
    } grant_e;

endpackage

// File: rtl/fb_wbuf.sv
// One-entry host write buffer with valid/ready on the input side.
// Latency: an accepted write can drain from the cycle after acceptance.
// Backpressure: ready drops only while full and the current cycle cannot drain it.
// Ports: in_* = host handshake; drain_ok_i = RAM slot free for the buffered write;
//        out_* = buffered entry presented to the arbiter.
module fb_wbuf #(
    parameter int AW = 11,
    parameter int DW = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_vld_i,
    output logic          in_rdy_o,
    input  logic [AW-1:0] in_addr_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          drain_ok_i,
    output logic          out_vld_o,
    output logic [AW-1:0] out_addr_o,
    output logic [DW-1:0] out_data_o
);

    logic          full_q;
    logic          full_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          accept;

    // A draining entry frees the slot in the same cycle, so a new write
    // can be taken while the old one goes to RAM: one write per free cycle.
    assign in_rdy_o = !full_q || drain_ok_i;
    assign accept   = in_vld_i && in_rdy_o;
    assign full_d   = accept || (full_q && !drain_ok_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            if (accept) begin
                addr_q <= in_addr_i;
                data_q <= in_data_i;
            end
        end
    end

    assign out_vld_o  = full_q;
    assign out_addr_o = addr_q;
    assign out_data_o = data_q;

endmodule

// File: rtl/fb_arbiter.sv
// Arbitrates the single-port LED frame RAM: display reads > zero-fill clear > buffered host writes.
// Latency: display read data 2 cycles after rd_req_i, always; RAM control is combinational.
// Backpressure: host wr_ready_o drops only while the 1-entry buffer is full and stalled.
// Build option DOUBLE_BUF_EN: adds a bank bit (ram_addr_o MSB); reads use the display bank,
//   writes/clear use the back bank, swapped at frame_end_i after swap_req_i.
// Ports: rd_* display read; wr_* host write handshake; clr_* zero-fill control;
//        frame_end_i/swap_req_i/swap_done_o bank swap; ram_* single-port RAM interface.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter  int ROW_W   = FB_ROW_W,
    parameter  int COL_W   = FB_COL_W,
    parameter  int DATA_W  = FB_DATA_W,
    localparam int BASE_AW = ROW_W + COL_W,
    localparam int AW      = BASE_AW + FB_BANK_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               rd_req_i,
    input  logic [ROW_W-1:0]   rd_row_i,
    input  logic [COL_W-1:0]   rd_col_i,
    output logic               rd_valid_o,
    output logic [DATA_W-1:0]  rd_data_o,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    input  logic [BASE_AW-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]  wr_data_i,
    input  logic               clr_req_i,
    output logic               clr_busy_o,
    input  logic               frame_end_i,
    input  logic               swap_req_i,
    output logic               swap_done_o,
    output logic               ram_en_o,
    output logic               ram_we_o,
    output logic [AW-1:0]      ram_addr_o,
    output logic [DATA_W-1:0]  ram_wdata_o,
    input  logic [DATA_W-1:0]  ram_rdata_i
);

    fsm_e               state_q;
    logic [BASE_AW-1:0] clr_ctr_q;
    logic               clr_busy_q;

    logic               rd_pend_q;
    logic               rd_valid_q;
    logic [DATA_W-1:0]  rd_data_q;

    grant_e             grant;
    logic [BASE_AW-1:0] addr_base;

    logic               wb_vld;
    logic [BASE_AW-1:0] wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               drain_ok;

    // ------------------------------------------------------------------
    // Host write buffer: drains in any cycle not taken by a read or clear.
    // ------------------------------------------------------------------
    assign drain_ok = !rd_req_i && (state_q != CLEAR);

    fb_wbuf #(
        .AW (BASE_AW),
        .DW (DATA_W)
    ) u_wbuf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_vld_i   (wr_valid_i),
        .in_rdy_o   (wr_ready_o),
        .in_addr_i  (wr_addr_i),
        .in_data_i  (wr_data_i),
        .drain_ok_i (drain_ok),
        .out_vld_o  (wb_vld),
        .out_addr_o (wb_addr),
        .out_data_o (wb_data)
    );

    // ------------------------------------------------------------------
    // Per-cycle arbitration and RAM control.
    // ------------------------------------------------------------------
    always_comb begin
        grant = G_NONE;
        if (rd_req_i) begin
            grant = G_RD;
        end else if (state_q == CLEAR) begin
            grant = G_CLR;
        end else if (wb_vld) begin
            grant = G_WR;
        end
    end

    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        addr_base   = '0;
        ram_wdata_o = '0;
        case (grant)
            G_RD: begin
                ram_en_o  = 1'b1;
                addr_base = {rd_row_i, rd_col_i};
            end
            G_CLR: begin
                ram_en_o  = 1'b1;
                ram_we_o  = 1'b1;
                addr_base = clr_ctr_q;
            end
            G_WR: begin
                ram_en_o    = 1'b1;
                ram_we_o    = 1'b1;
                addr_base   = wb_addr;
                ram_wdata_o = wb_data;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Clear engine: one zero write per cycle not taken by a display read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            clr_ctr_q  <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req_i) begin
                        state_q    <= CLEAR;
                        clr_ctr_q  <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clr_req_i is deliberately ignored here.
                    if (grant == G_CLR) begin
                        if (clr_ctr_q == {BASE_AW{1'b1}}) begin
                            state_q    <= IDLE;
                            clr_busy_q <= 1'b0;
                        end else begin
                            clr_ctr_q <= clr_ctr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy_o = clr_busy_q;

    // ------------------------------------------------------------------
    // Read return: RAM data appears the cycle after the access and is
    // registered once more, giving a fixed 2-cycle latency.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_pend_q  <= rd_req_i;
            rd_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                rd_data_q <= ram_rdata_i;
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

    // The scan sequencer never issues reads in back-to-back cycles.
    rd_spacing_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                   rd_req_i |-> !rd_pend_q);

    // ------------------------------------------------------------------
    // Bank selection and swap.
    // ------------------------------------------------------------------
`ifdef DOUBLE_BUF_EN
    logic disp_bank_q;
    logic swap_pend_q;
    logic swap_done_q;
    logic swap_fire;
    logic bank_sel;

    // Swap only with the buffer empty so a queued write cannot land in
    // the bank that has just become visible.
    assign swap_fire = frame_end_i && swap_pend_q && !wb_vld;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            disp_bank_q <= 1'b0;
            swap_pend_q <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            swap_done_q <= swap_fire;
            if (swap_fire) begin
                disp_bank_q <= ~disp_bank_q;
                swap_pend_q <= swap_req_i;
            end else if (swap_req_i) begin
                swap_pend_q <= 1'b1;
            end
        end
    end

    assign bank_sel    = (grant == G_RD) ? disp_bank_q : ~disp_bank_q;
    assign ram_addr_o  = {bank_sel, addr_base};
    assign swap_done_o = swap_done_q;
`else
    logic unused_swap_in;
    assign unused_swap_in = frame_end_i ^ swap_req_i;
    assign ram_addr_o     = addr_base;
    assign swap_done_o    = 1'b0;
`endif

endmodule
